// File: rtl/vga_pkg.sv
// vga_pkg: 640x480 timing constants shared with the display driver, plus error and FSM enumerations
package vga_pkg;
  localparam int H_TOTAL = 800;
  localparam int HS_W    = 96;
  localparam int V_TOTAL = 521;
  localparam int VS_W    = 2;
  localparam int H_ACT0  = 144;
  localparam int V_ACT0  = 31;
  localparam int H_ACT   = 640;
  localparam int V_ACT   = 480;
  typedef enum logic [1:0] {ERR_HS_WIDTH, ERR_LINE_LEN, ERR_VS_WIDTH, ERR_FRAME_LEN} err_code_e;
  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} rx_state_e;
endpackage

// File: rtl/sync_width_chk.sv
// sync_width_chk: active-low sync checker; counts position since the falling edge and checks low width and period
// ports: level/strobe in (level sampled only on strobe), width/period expected values,
//        start = falling-edge pulse, width_err at rising edge, period_err once per period, count = position
module sync_width_chk (
  input  logic       clk,
  input  logic       rst,
  input  logic       level,
  input  logic       strobe,
  input  logic [9:0] width,
  input  logic [9:0] period,
  output logic       start,
  output logic       width_err,
  output logic       period_err,
  output logic [9:0] count
);
  logic       prev;
  logic [9:0] low;
  assign start      = strobe & ~level & prev;
  assign width_err  = strobe & level & ~prev & (low != width);
  // a period that already saturated was flagged when it hit the limit, so its late edge is not flagged again
  assign period_err = start ? (count != period - 10'd1 && count != period)
                            : (strobe && count == period - 10'd1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      prev  <= 1'b1;
      low   <= '0;
      count <= '0;
    end else if (strobe) begin
      prev  <= level;
      low   <= level ? low : prev ? 10'd1 : low + {9'd0, low != '1};
      count <= start ? '0 : count + {9'd0, count != period};
    end
endmodule

// File: rtl/vga_rx.sv
// vga_rx: VGA timing recoverer and frame checker with active-pixel output and per-frame lit count
// ports: clk, rst (async active-low); hs/vs/rgb sampled inputs;
//        locked, pix_valid/pix_x/pix_y/pix_rgb, frame_done, lit_count, err/err_code
module vga_rx import vga_pkg::*; #(
  parameter int H_TOTAL     = vga_pkg::H_TOTAL,
  parameter int HS_W        = vga_pkg::HS_W,
  parameter int V_TOTAL     = vga_pkg::V_TOTAL,
  parameter int VS_W        = vga_pkg::VS_W,
  parameter int H_ACT0      = vga_pkg::H_ACT0,
  parameter int V_ACT0      = vga_pkg::V_ACT0,
  parameter int H_ACT       = vga_pkg::H_ACT,
  parameter int V_ACT       = vga_pkg::V_ACT,
  parameter int RGB_LAG     = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic [11:0] rgb,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_done,
  output logic [18:0] lit_count,
  output logic        err,
  output logic [1:0]  err_code
);
  localparam logic [9:0] HA0  = 10'(H_ACT0);
  localparam logic [9:0] HEND = 10'(H_ACT0 + H_ACT);
  localparam logic [9:0] VA0  = 10'(V_ACT0);
  localparam logic [9:0] VEND = 10'(V_ACT0 + V_ACT);
  localparam logic [9:0] LAG  = 10'(RGB_LAG);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
  rx_state_e   state_q, state_d;
  err_code_e   code_d;
  logic [3:0]  good_q, good_d;
  logic        hs_s1, vs_s1;
  logic [11:0] rgb_s1, rgb_s2;
  logic        ls, fs, e_hw, e_ll, e_vw, e_fl, any_err, act, err_d, done_d;
  logic [9:0]  h_rx, v_rx, hc;
  logic [18:0] lit;
  // the checker's own previous-level flop is the second hs stage
  sync_width_chk u_hchk (
    .clk(clk), .rst(rst), .level(hs_s1), .strobe(1'b1),
    .width(10'(HS_W)), .period(10'(H_TOTAL)),
    .start(ls), .width_err(e_hw), .period_err(e_ll), .count(h_rx)
  );
  // vs is sampled once per line; the checker's previous level is vs_line
  sync_width_chk u_vchk (
    .clk(clk), .rst(rst), .level(vs_s1), .strobe(ls),
    .width(10'(VS_W)), .period(10'(V_TOTAL)),
    .start(fs), .width_err(e_vw), .period_err(e_fl), .count(v_rx)
  );
  // rgb_s2 belongs to the hcount RGB_LAG behind h_rx; below zero it wraps out of range
  assign hc      = h_rx - LAG;
  assign act     = hc >= HA0 && hc < HEND && v_rx >= VA0 && v_rx < VEND;
  assign any_err = e_hw | e_ll | e_vw | e_fl;
  assign locked  = state_q == LOCKED;
  always_comb begin
    code_d  = e_hw ? ERR_HS_WIDTH : e_ll ? ERR_LINE_LEN : e_vw ? ERR_VS_WIDTH : ERR_FRAME_LEN;
    err_d   = state_q != SEARCH && any_err;
    done_d  = state_q != SEARCH && !any_err && fs && (state_q == LOCKED || good_q + 4'd1 >= LOCK_N);
    good_d  = state_q == SEARCH ? 4'd0 : (fs && !any_err) ? good_q + 4'd1 : good_q;
    state_d = err_d ? SEARCH : done_d ? LOCKED : (state_q == SEARCH && fs) ? CHECK : state_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= SEARCH;
      good_q     <= '0;
      hs_s1      <= 1'b1;
      vs_s1      <= 1'b1;
      rgb_s1     <= '0;
      rgb_s2     <= '0;
      lit        <= '0;
      lit_count  <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_rgb    <= '0;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      hs_s1      <= hs;
      vs_s1      <= vs;
      rgb_s1     <= rgb;
      rgb_s2     <= rgb_s1;
      lit        <= fs ? '0 : lit + 19'(act && rgb_s2 != '0);
      lit_count  <= done_d ? lit : lit_count;
      frame_done <= done_d;
      err        <= err_d;
      err_code   <= err_d ? code_d : err_code;
      pix_valid  <= act && locked;
      pix_x      <= hc - HA0;
      pix_y      <= v_rx - VA0;
      pix_rgb    <= rgb_s2;
    end
endmodule
